el2_dec_ib_queue: RTL and testbench

- Instruction-buffer queue between the IFU aligner and the decode IB control stage.
- Captures aligner i0 packets (instruction, PC, PC4, fault and ECC attributes) into a small FIFO.
- Presents the head entry to decode as the ifu_i0_* bundle.
- Applies backpressure to the aligner while full and discards all contents on a pipeline flush.

---
 rtl/el2_dec_ib_queue_pkg.sv | 17 +
 rtl/el2_dec_ib_queue_enff.sv | 24 ++
 rtl/el2_dec_ib_queue.sv | 119 +++++++++++
 tb/tb_el2_dec_ib_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/el2_dec_ib_queue_pkg.sv
// Shared types for the decode instruction-buffer queue.
// One packet is everything the aligner hands decode for a single i0 instruction.
package el2_dec_ib_queue_pkg;

    typedef struct packed {
        logic        icaf_second;
        logic        dbecc;
        logic        icaf;
        logic [1:0]  icaf_type;
        logic [31:1] pc;
        logic        pc4;
        logic [31:0] instr;
    } el2_ib_pkt_t;

    localparam int unsigned IB_PKT_W = $bits(el2_ib_pkt_t);

endpackage

// File: rtl/el2_dec_ib_queue_enff.sv
// Enable flop cell: async active-low reset to zero, loads only when enabled.
module el2_dec_ib_queue_enff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_l,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/el2_dec_ib_queue.sv
// Instruction-buffer FIFO between the IFU aligner and decode.
// Head entry is presented combinationally and masked to zero while empty.
module el2_dec_ib_queue
    import el2_dec_ib_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              exu_flush_final,
    input  logic              aln_valid,
    output logic              aln_ready,
    input  logic [31:0]       aln_instr,
    input  logic [31:1]       aln_pc,
    input  logic              aln_pc4,
    input  logic              aln_icaf,
    input  logic [1:0]        aln_icaf_type,
    input  logic              aln_icaf_second,
    input  logic              aln_dbecc,
    input  logic              dec_i0_decode_d,
    output logic              ifu_i0_valid,
    output logic [31:0]       ifu_i0_instr,
    output logic [31:1]       ifu_i0_pc,
    output logic              ifu_i0_pc4,
    output logic              ifu_i0_icaf,
    output logic [1:0]        ifu_i0_icaf_type,
    output logic              ifu_i0_icaf_second,
    output logic              ifu_i0_dbecc,
    output logic [PTR_W:0]    ib_count
);

    localparam logic [PTR_W:0]   LP_CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LP_PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_wr_ptr_inc;
    logic [PTR_W-1:0] w_rd_ptr_inc;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_wr_en;
    logic             w_rd_en;

    el2_ib_pkt_t w_wr_pkt;
    el2_ib_pkt_t w_head;
    el2_ib_pkt_t w_head_m;
    el2_ib_pkt_t w_mem [DEPTH];

    // No pop-through: a full queue stays not-ready even if decode drains it this cycle.
    assign aln_ready    = (r_count != LP_CNT_FULL) & ~exu_flush_final;
    assign ifu_i0_valid = (r_count != '0);
    assign w_wr_en      = aln_valid & aln_ready;
    assign w_rd_en      = dec_i0_decode_d & ifu_i0_valid;

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wr_ptr_inc = (r_wr_ptr == LP_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = (r_rd_ptr == LP_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (exu_flush_final) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= w_wr_ptr_inc;
            if (w_rd_en) r_rd_ptr <= w_rd_ptr_inc;
            r_count <= w_count_nxt;
        end
    end

    assign w_wr_pkt = '{
        icaf_second: aln_icaf_second,
        dbecc:       aln_dbecc,
        icaf:        aln_icaf,
        icaf_type:   aln_icaf_type,
        pc:          aln_pc,
        pc4:         aln_pc4,
        instr:       aln_instr
    };

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        el2_dec_ib_queue_enff #(
            .WIDTH (IB_PKT_W)
        ) u_entry (
            .i_clk   (clk),
            .i_rst_l (rst_l),
            .i_en    (w_wr_en && (r_wr_ptr == PTR_W'(gi))),
            .i_d     (w_wr_pkt),
            .o_q     (w_mem[gi])
        );
    end

    assign w_head   = w_mem[r_rd_ptr];
    assign w_head_m = ifu_i0_valid ? w_head : '0;

    assign ifu_i0_instr       = w_head_m.instr;
    assign ifu_i0_pc          = w_head_m.pc;
    assign ifu_i0_pc4         = w_head_m.pc4;
    assign ifu_i0_icaf        = w_head_m.icaf;
    assign ifu_i0_icaf_type   = w_head_m.icaf_type;
    assign ifu_i0_icaf_second = w_head_m.icaf_second;
    assign ifu_i0_dbecc       = w_head_m.dbecc;
    assign ib_count           = r_count;

endmodule

// File: tb/tb_el2_dec_ib_queue.sv
// Randomised scoreboard bench for el2_dec_ib_queue with directed scenarios up front.
module tb_el2_dec_ib_queue;
    import el2_dec_ib_queue_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic           clk = 1'b0;
    logic           rst_l = 1'b0;
    logic           exu_flush_final = 1'b0;
    logic           aln_valid = 1'b0;
    logic           aln_ready;
    logic [31:0]    aln_instr = '0;
    logic [31:1]    aln_pc = '0;
    logic           aln_pc4 = 1'b0;
    logic           aln_icaf = 1'b0;
    logic [1:0]     aln_icaf_type = '0;
    logic           aln_icaf_second = 1'b0;
    logic           aln_dbecc = 1'b0;
    logic           dec_i0_decode_d = 1'b0;
    logic           ifu_i0_valid;
    logic [31:0]    ifu_i0_instr;
    logic [31:1]    ifu_i0_pc;
    logic           ifu_i0_pc4;
    logic           ifu_i0_icaf;
    logic [1:0]     ifu_i0_icaf_type;
    logic           ifu_i0_icaf_second;
    logic           ifu_i0_dbecc;
    logic [PTR_W:0] ib_count;

    el2_dec_ib_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .exu_flush_final    (exu_flush_final),
        .aln_valid          (aln_valid),
        .aln_ready          (aln_ready),
        .aln_instr          (aln_instr),
        .aln_pc             (aln_pc),
        .aln_pc4            (aln_pc4),
        .aln_icaf           (aln_icaf),
        .aln_icaf_type      (aln_icaf_type),
        .aln_icaf_second    (aln_icaf_second),
        .aln_dbecc          (aln_dbecc),
        .dec_i0_decode_d    (dec_i0_decode_d),
        .ifu_i0_valid       (ifu_i0_valid),
        .ifu_i0_instr       (ifu_i0_instr),
        .ifu_i0_pc          (ifu_i0_pc),
        .ifu_i0_pc4         (ifu_i0_pc4),
        .ifu_i0_icaf        (ifu_i0_icaf),
        .ifu_i0_icaf_type   (ifu_i0_icaf_type),
        .ifu_i0_icaf_second (ifu_i0_icaf_second),
        .ifu_i0_dbecc       (ifu_i0_dbecc),
        .ib_count           (ib_count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of packets the queue should hold.
    el2_ib_pkt_t exp_q[$];
    bit          push_pending = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    el2_ib_pkt_t dut_head;
    assign dut_head = {ifu_i0_icaf_second, ifu_i0_dbecc, ifu_i0_icaf, ifu_i0_icaf_type,
                       ifu_i0_pc, ifu_i0_pc4, ifu_i0_instr};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    function automatic el2_ib_pkt_t mk(input logic [31:0] instr, input logic [31:1] pc,
                                       input logic pc4, input logic icaf,
                                       input logic [1:0] icaf_type, input logic icaf_second,
                                       input logic dbecc);
        el2_ib_pkt_t p;
        p.instr       = instr;
        p.pc          = pc;
        p.pc4         = pc4;
        p.icaf        = icaf;
        p.icaf_type   = icaf_type;
        p.icaf_second = icaf_second;
        p.dbecc       = dbecc;
        return p;
    endfunction

    function automatic el2_ib_pkt_t rand_pkt();
        return mk($urandom, 31'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom));
    endfunction

    // One clock of stimulus; the model predicts acceptance from its own occupancy.
    task automatic cycle(input bit v, input el2_ib_pkt_t p, input bit d, input bit f,
                         output bit acc);
        @(posedge clk);
        #1;
        aln_valid       = v;
        aln_instr       = p.instr;
        aln_pc          = p.pc;
        aln_pc4         = p.pc4;
        aln_icaf        = p.icaf;
        aln_icaf_type   = p.icaf_type;
        aln_icaf_second = p.icaf_second;
        aln_dbecc       = p.dbecc;
        dec_i0_decode_d = d;
        exu_flush_final = f;
        acc = v && !f && (exp_q.size() < DEPTH);
        if (acc) exp_q.push_back(p);
        push_pending = acc;
    endtask

    // Monitor: compares the DUT against the model, then retires pops and flushes.
    always @(negedge clk) begin : monitor
        int committed;
        if (rst_l) begin
            committed = exp_q.size() - (push_pending ? 1 : 0);
            chk("aln_ready", aln_ready, (committed < DEPTH) && !exu_flush_final);
            chk("ib_count", ib_count, committed);
            chk("ifu_i0_valid", ifu_i0_valid, committed != 0);
            if (committed != 0) chk("head_pkt", dut_head, exp_q[0]);
            else                chk("idle_data_zero", dut_head, '0);
            if (exu_flush_final) exp_q.delete();
            else if (dec_i0_decode_d && committed != 0) void'(exp_q.pop_front());
            push_pending = 1'b0;
        end
    end

    initial begin
        el2_ib_pkt_t z;
        el2_ib_pkt_t p;
        el2_ib_pkt_t held;
        bit          have_held;
        bit          acc;
        z = '0;
        have_held = 1'b0;

        #12 rst_l = 1'b1;
        repeat (3) cycle(0, z, 0, 0, acc);

        // Single push, one-cycle latency, then decode.
        cycle(1, mk(32'h00A00093, 31'h800, 1, 0, 0, 0, 0), 0, 0, acc);
        cycle(0, z, 0, 0, acc);
        cycle(0, z, 1, 0, acc);
        cycle(0, z, 0, 0, acc);

        // Backpressure at full, no pop-through, order preserved.
        cycle(1, mk(32'h11, 31'h10, 0, 0, 0, 0, 0), 0, 0, acc);
        cycle(1, mk(32'h22, 31'h20, 0, 0, 0, 0, 0), 0, 0, acc);
        cycle(1, mk(32'h33, 31'h30, 0, 0, 0, 0, 0), 0, 0, acc);
        cycle(1, mk(32'h33, 31'h30, 0, 0, 0, 0, 0), 1, 0, acc);
        cycle(1, mk(32'h33, 31'h30, 0, 0, 0, 0, 0), 0, 0, acc);
        repeat (3) cycle(0, z, 1, 0, acc);

        // Steady stream: one in, one out every cycle, pointers wrap.
        cycle(1, mk(32'h100, 31'h100, 1, 0, 0, 0, 0), 0, 0, acc);
        for (int i = 1; i <= 10; i++)
            cycle(1, mk(32'h100 + i, 31'(32'h100 + 2 * i), 1, 0, 0, 0, 0), 1, 0, acc);
        repeat (2) cycle(0, z, 1, 0, acc);

        // Flush of a full queue with a packet on offer.
        cycle(1, mk(32'hA1, 31'h50, 0, 0, 0, 0, 0), 0, 0, acc);
        cycle(1, mk(32'hA2, 31'h52, 0, 0, 0, 0, 0), 0, 0, acc);
        cycle(1, mk(32'hDEAD, 31'h54, 0, 0, 0, 0, 0), 1, 1, acc);
        cycle(0, z, 0, 0, acc);
        cycle(1, mk(32'hB1, 31'h60, 0, 0, 0, 0, 0), 0, 0, acc);
        repeat (2) cycle(0, z, 1, 0, acc);

        // Fault attributes travel with the entry; decode on empty is ignored.
        cycle(1, mk(32'hC0FFEE, 31'h70, 1, 1, 2'b10, 1, 0), 0, 0, acc);
        cycle(0, z, 1, 0, acc);
        repeat (3) cycle(0, z, 1, 0, acc);

        // Random traffic; aligner holds a refused packet until taken or flushed.
        for (int i = 0; i < 800; i++) begin
            bit v;
            bit d;
            bit f;
            if (i == 400) begin
                cycle(0, z, 0, 0, acc);
                #2 rst_l = 1'b0;
                #1;
                chk("async_reset_count", ib_count, 0);
                chk("async_reset_valid", ifu_i0_valid, 0);
                chk("async_reset_data", dut_head, '0);
                exp_q.delete();
                have_held = 1'b0;
                @(negedge clk);
                #2 rst_l = 1'b1;
            end
            if (!have_held) begin
                held = rand_pkt();
                have_held = ($urandom_range(0, 99) < 70);
            end
            v = have_held;
            d = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 99) < 5);
            p = held;
            cycle(v, p, d, f, acc);
            if (acc || f) have_held = 1'b0;
        end

        repeat (3) cycle(0, z, 1, 0, acc);
        cycle(0, z, 0, 0, acc);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
